cache_mem_arbiter: RTL and testbench

//  Shares the single physical-memory line port between the icache and dcache controllers.

---
 rtl/cache_arb_pkg.sv | 18 +
 rtl/arb_rr2.sv | 23 ++
 rtl/cache_mem_arbiter.sv | 102 ++++++++++
 tb/tb_cache_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the cache/memory line-port arbiters.
package cache_arb_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
    localparam int unsigned DEFAULT_LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin picker: on a tie, grants the side that did not win last time.
module arb_rr2
    import cache_arb_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    output logic [1:0] gnt,
    output logic       any
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == GRANT_D) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    assign any = |req;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single physical-memory line port between the icache and dcache.
// A grant is held for a whole line transaction and released on mem_resp.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH = DEFAULT_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    arb_state_t state, state_next;
    grant_t     last_grant, last_grant_next;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       any;

    assign req = {d_pmem_read | d_pmem_write, i_pmem_read};

    arb_rr2 u_rr2 (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (gnt),
        .any        (any)
    );

    // last_grant resets to D so the icache wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        i_pmem_resp     = 1'b0;
        d_pmem_resp     = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    state_next = gnt[0] ? SERVE_I : SERVE_D;
                end
            end
            SERVE_I: begin
                mem_read    = i_pmem_read;
                mem_address = i_pmem_address;
                i_pmem_resp = mem_resp;
                if (mem_resp) begin
                    state_next      = IDLE;
                    last_grant_next = GRANT_I;
                end
            end
            SERVE_D: begin
                mem_read    = d_pmem_read;
                mem_write   = d_pmem_write;
                mem_address = d_pmem_address;
                d_pmem_resp = mem_resp;
                if (mem_resp) begin
                    state_next      = IDLE;
                    last_grant_next = GRANT_D;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_wdata    = d_pmem_wdata;
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

    // The dcache never issues a fill and a write-back at once.
    assert property (@(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of who owns the memory port.
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    int vectors = 0;
    int errors  = 0;

    // Model: owner of the port (0 none, 1 icache, 2 dcache) and last side served.
    int owner;
    int last;
    int grants[$];

    bit auto_mem;
    bit auto_req;
    bit gen_req;
    bit contention;
    int mem_cnt;
    bit timed_out;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [LW-1:0] obs,
                              input logic [LW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return $urandom() & 32'hFFFF_FFE0;
    endfunction

    // One clock: check outputs at negedge, advance the model, then update stimulus at posedge+1.
    task automatic cycle();
        logic exp_rd, exp_wr, exp_ir, exp_dr;
        bit   iq, dq;
        @(negedge clk);
        exp_rd = (owner == 1) ? i_pmem_read : (owner == 2) ? d_pmem_read : 1'b0;
        exp_wr = (owner == 2) ? d_pmem_write : 1'b0;
        exp_ir = (owner == 1) && mem_resp;
        exp_dr = (owner == 2) && mem_resp;
        check_bit("mem_read", mem_read, exp_rd);
        check_bit("mem_write", mem_write, exp_wr);
        check_bit("i_pmem_resp", i_pmem_resp, exp_ir);
        check_bit("d_pmem_resp", d_pmem_resp, exp_dr);
        if (owner == 1) check_line("mem_address_i", LW'(mem_address), LW'(i_pmem_address));
        if (owner == 2) check_line("mem_address_d", LW'(mem_address), LW'(d_pmem_address));
        check_line("mem_wdata", mem_wdata, d_pmem_wdata);
        check_line("i_pmem_rdata", i_pmem_rdata, mem_rdata);
        check_line("d_pmem_rdata", d_pmem_rdata, mem_rdata);

        if (owner == 0) begin
            iq = i_pmem_read;
            dq = d_pmem_read | d_pmem_write;
            if (iq && dq) owner = (last == 2) ? 1 : 2;
            else if (iq)  owner = 1;
            else if (dq)  owner = 2;
            if (owner != 0) grants.push_back(owner);
        end else if (mem_resp) begin
            last  = owner;
            owner = 0;
        end

        @(posedge clk);
        #1;
        if (auto_mem) begin
            if (mem_resp) begin
                mem_resp = 1'b0;
                mem_cnt  = -1;
            end else if (exp_rd || exp_wr) begin
                if (mem_cnt < 0) mem_cnt = $urandom_range(0, 4);
                if (mem_cnt == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = rand_line();
                end else begin
                    mem_cnt--;
                end
            end
        end
        if (auto_req) begin
            if (exp_ir) begin
                i_pmem_read = 1'b0;
            end else if (!i_pmem_read && gen_req && (contention || $urandom_range(0, 2) == 0)) begin
                i_pmem_read    = 1'b1;
                i_pmem_address = rand_addr();
            end
            if (exp_dr) begin
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
            end else if (!d_pmem_read && !d_pmem_write && gen_req &&
                         (contention || $urandom_range(0, 2) == 0)) begin
                d_pmem_address = rand_addr();
                d_pmem_wdata   = rand_line();
                if ($urandom_range(0, 1) == 1) d_pmem_write = 1'b1;
                else                           d_pmem_read  = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        owner = 0; last = 2; mem_cnt = -1;
        auto_mem = 0; auto_req = 0; gen_req = 0; contention = 0; timed_out = 0;

        // Held in reset: everything quiet.
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // icache fill of 0x1000, memory answers after five cycles.
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
        cycle();
        check_bit("t2_mem_read_n1", mem_read, 1'b1);
        check_line("t2_addr", LW'(mem_address), LW'(32'h0000_1000));
        repeat (4) cycle();
        mem_rdata = {32{8'hA5}};
        mem_resp  = 1'b1;
        #1;
        check_bit("t2_i_resp", i_pmem_resp, 1'b1);
        check_bit("t2_d_resp", d_pmem_resp, 1'b0);
        check_line("t2_i_rdata", i_pmem_rdata, {32{8'hA5}});
        cycle();
        mem_resp = 1'b0; i_pmem_read = 1'b0;
        cycle();

        // dcache write-back of 0x2040.
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_2040; d_pmem_wdata = {8{32'h1234_5678}};
        cycle();
        check_bit("t3_mem_write", mem_write, 1'b1);
        check_line("t3_wdata", mem_wdata, {8{32'h1234_5678}});
        check_line("t3_addr", LW'(mem_address), LW'(32'h0000_2040));
        repeat (2) cycle();
        mem_resp = 1'b1;
        #1;
        check_bit("t3_d_resp", d_pmem_resp, 1'b1);
        check_bit("t3_i_resp", i_pmem_resp, 1'b0);
        cycle();
        mem_resp = 1'b0; d_pmem_write = 1'b0;
        cycle();
        check_bit("t3_idle_write", mem_write, 1'b0);

        // Reset lands in the middle of a dcache write-back.
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_3000;
        cycle();
        check_bit("t1_write_before_rst", mem_write, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("t1_write_in_rst", mem_write, 1'b0);
        check_bit("t1_dresp_in_rst", d_pmem_resp, 1'b0);
        owner = 0; last = 2;
        d_pmem_write = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        check_bit("t1_read_after_rst", mem_read, 1'b0);
        check_bit("t1_write_after_rst", mem_write, 1'b0);

        // Tie right after reset: icache first, one idle cycle, then dcache.
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_4000;
        d_pmem_read = 1'b1; d_pmem_address = 32'h0000_5000;
        cycle();
        check_line("t4_first_addr", LW'(mem_address), LW'(32'h0000_4000));
        mem_resp = 1'b1;
        cycle();
        mem_resp = 1'b0; i_pmem_read = 1'b0;
        #1;
        check_bit("t4_gap_read", mem_read, 1'b0);
        cycle();
        check_line("t4_second_addr", LW'(mem_address), LW'(32'h0000_5000));
        check_bit("t4_second_read", mem_read, 1'b1);
        mem_resp = 1'b1;
        cycle();
        mem_resp = 1'b0; d_pmem_read = 1'b0;
        cycle();

        // Continuous contention: dcache went last, so icache leads and they alternate.
        grants.delete();
        auto_mem = 1; auto_req = 1; gen_req = 1; contention = 1;
        for (int k = 0; k < 400 && grants.size() < 6; k++) cycle();
        check_bit("t5_enough_grants", grants.size() >= 6, 1'b1);
        if (grants.size() > 0) check_bit("t5_first_is_i", grants[0] == 1, 1'b1);
        for (int k = 1; k < 6 && k < grants.size(); k++)
            check_bit("t5_alternate", grants[k] != grants[k-1], 1'b1);

        // Random traffic with random memory latency.
        contention = 0;
        for (int k = 0; k < 1500; k++) cycle();
        gen_req = 0;
        for (int k = 0; k < 500 && (owner != 0 || i_pmem_read || d_pmem_read ||
                                    d_pmem_write || mem_resp); k++) cycle();
        timed_out = (owner != 0) || i_pmem_read || d_pmem_read || d_pmem_write || mem_resp;
        check_bit("drain_done", timed_out, 1'b0);
        auto_mem = 0; auto_req = 0; mem_cnt = -1;
        cycle();

        // dcache arrives during an icache grant and must wait for its mem_resp.
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_6000;
        cycle();
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_7000; d_pmem_wdata = rand_line();
        repeat (3) cycle();
        check_bit("t6_d_waits", mem_write, 1'b0);
        mem_resp = 1'b1;
        cycle();
        mem_resp = 1'b0; i_pmem_read = 1'b0;
        cycle();
        check_bit("t6_d_served", mem_write, 1'b1);
        check_line("t6_d_addr", LW'(mem_address), LW'(32'h0000_7000));
        mem_resp = 1'b1;
        cycle();
        d_pmem_write = 1'b0;
        // Stray response while idle is dropped.
        #1;
        check_bit("t6_stray_i", i_pmem_resp, 1'b0);
        check_bit("t6_stray_d", d_pmem_resp, 1'b0);
        cycle();
        mem_resp = 1'b0;
        repeat (2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
